// File: rtl/watch_pkg.sv
// Shared limits, reset values and the month-length helper for the watch core.
// Build option: define LEAP_YEAR_EN to give February 29 days when year[1:0] == 0.
package watch_pkg;

  localparam logic [7:0] SEC_MAX   = 8'd59;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MONTH_MAX = 8'd12;

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } cal_t;

  localparam cal_t CAL_RESET = '{year: 8'd0, month: 8'd1, day: 8'd1,
                                 hour: 8'd0, minute: 8'd0, second: 8'd0};

  // Returns 0 for an out-of-range month so callers can treat it as invalid.
  function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [7:0] year);
    logic [7:0] d;
    logic       leap;
`ifdef LEAP_YEAR_EN
    leap = ((year & 8'd3) == 8'd0);
`else
    leap = ((year & 8'd0) != 8'd0);
`endif
    case (month)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: d = 8'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    d = 8'd30;
      8'd2:                                       d = leap ? 8'd29 : 8'd28;
      default:                                    d = 8'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/watch_alarm_ch.sv
// One alarm channel: compare time, enable and a latched flag.
// Write clears the flag; a match in a tick cycle sets it; ack clears it (set wins).
module watch_alarm_ch (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] wr_hour,
  input  logic [7:0] wr_minute,
  input  logic [7:0] wr_second,
  input  logic       wr_en,
  input  logic       ack,
  input  logic       match_en,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  output logic       flag
);

  logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic       en_q, en_d, flag_q, flag_d;
  logic       hit;

  // Next-state for compare registers and flag
  always_comb begin
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    en_d     = en_q;
    flag_d   = flag_q;
    hit      = match_en && en_q && (hour_q == cur_hour) &&
               (minute_q == cur_minute) && (second_q == cur_second);
    if (wr) begin
      hour_d   = wr_hour;
      minute_d = wr_minute;
      second_d = wr_second;
      en_d     = wr_en;
      flag_d   = 1'b0;
    end else if (hit) begin
      flag_d = 1'b1;
    end else if (ack) begin
      flag_d = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      en_q     <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      en_q     <= en_d;
      flag_q   <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/watch_calendar_alarm.sv
// Time-of-day/calendar core: 1 Hz prescaler, carry chain, validated load and
// NUM_ALARM alarm channels. Build option LEAP_YEAR_EN (see watch_pkg).
module watch_calendar_alarm
  import watch_pkg::*;
#(
  parameter  int CLK_HZ    = 50_000_000,
  parameter  int NUM_ALARM = 4,
  parameter  int YEAR_MAX  = 99,
  localparam int SEL_W     = (NUM_ALARM > 1) ? $clog2(NUM_ALARM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 load,
  input  logic [7:0]           set_year,
  input  logic [7:0]           set_month,
  input  logic [7:0]           set_day,
  input  logic [7:0]           set_hour,
  input  logic [7:0]           set_minute,
  input  logic [7:0]           set_second,
  output logic                 load_err,
  output logic [7:0]           year,
  output logic [7:0]           month,
  output logic [7:0]           day,
  output logic [7:0]           hour,
  output logic [7:0]           minute,
  output logic [7:0]           second,
  output logic                 tick_1hz,
  input  logic                 alarm_wr,
  input  logic [SEL_W-1:0]     alarm_sel,
  input  logic [7:0]           alarm_hour,
  input  logic [7:0]           alarm_minute,
  input  logic [7:0]           alarm_second,
  input  logic                 alarm_en_in,
  input  logic [NUM_ALARM-1:0] alarm_ack,
  output logic [NUM_ALARM-1:0] alarm_flag,
  output logic                 alarm_any
);

  localparam int         PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [7:0] YEAR_MAX_B = 8'(YEAR_MAX);

  cal_t          cal_q, cal_d, inc_cal, set_cal;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d, lerr_q, lerr_d;
  logic          wrap, load_ok;
  logic [7:0]    dim_cur, dim_set;
  logic [NUM_ALARM-1:0] flag_w;

  // Calendar value one second after the current one (ripple carry)
  always_comb begin
    inc_cal = cal_q;
    dim_cur = days_in_month(cal_q.month, cal_q.year);
    if (cal_q.second < SEC_MAX) begin
      inc_cal.second = cal_q.second + 8'd1;
    end else begin
      inc_cal.second = '0;
      if (cal_q.minute < MIN_MAX) begin
        inc_cal.minute = cal_q.minute + 8'd1;
      end else begin
        inc_cal.minute = '0;
        if (cal_q.hour < HOUR_MAX) begin
          inc_cal.hour = cal_q.hour + 8'd1;
        end else begin
          inc_cal.hour = '0;
          if (cal_q.day < dim_cur) begin
            inc_cal.day = cal_q.day + 8'd1;
          end else begin
            inc_cal.day = 8'd1;
            if (cal_q.month < MONTH_MAX) begin
              inc_cal.month = cal_q.month + 8'd1;
            end else begin
              inc_cal.month = 8'd1;
              inc_cal.year  = (cal_q.year < YEAR_MAX_B) ? cal_q.year + 8'd1 : '0;
            end
          end
        end
      end
    end
  end

  // Load field validation
  always_comb begin
    set_cal = '{year: set_year, month: set_month, day: set_day,
                hour: set_hour, minute: set_minute, second: set_second};
    dim_set = days_in_month(set_month, set_year);
    load_ok = (set_month >= 8'd1) && (set_month <= MONTH_MAX) &&
              (set_day >= 8'd1) && (set_day <= dim_set) &&
              (set_hour <= HOUR_MAX) && (set_minute <= MIN_MAX) &&
              (set_second <= SEC_MAX) && (set_year <= YEAR_MAX_B);
  end

  // Prescaler, time update and load arbitration (valid load beats the wrap)
  always_comb begin
    cal_d   = cal_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    lerr_d  = 1'b0;
    wrap    = run && (presc_q == PRESC_LAST);
    if (load && load_ok) begin
      cal_d   = set_cal;
      presc_d = '0;
    end else begin
      lerr_d = load;
      if (wrap) begin
        presc_d = '0;
        cal_d   = inc_cal;
        tick_d  = 1'b1;
      end else if (run) begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cal_q   <= CAL_RESET;
      presc_q <= '0;
      tick_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      cal_q   <= cal_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      lerr_q  <= lerr_d;
    end
  end

  for (genvar i = 0; i < NUM_ALARM; i++) begin : g_ch
    logic wr_i;
    assign wr_i = alarm_wr && (alarm_sel == SEL_W'(i));
    watch_alarm_ch u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_i),
      .wr_hour    (alarm_hour),
      .wr_minute  (alarm_minute),
      .wr_second  (alarm_second),
      .wr_en      (alarm_en_in),
      .ack        (alarm_ack[i]),
      .match_en   (tick_q),
      .cur_hour   (cal_q.hour),
      .cur_minute (cal_q.minute),
      .cur_second (cal_q.second),
      .flag       (flag_w[i])
    );
  end

  assign year       = cal_q.year;
  assign month      = cal_q.month;
  assign day        = cal_q.day;
  assign hour       = cal_q.hour;
  assign minute     = cal_q.minute;
  assign second     = cal_q.second;
  assign tick_1hz   = tick_q;
  assign load_err   = lerr_q;
  assign alarm_flag = flag_w;
  assign alarm_any  = |flag_w;

endmodule

// File: tb/tb_watch_calendar_alarm.sv
// Self-checking bench for watch_calendar_alarm with a small calendar model.
module tb_watch_calendar_alarm;

  localparam int CLK_HZ    = 10;
  localparam int NUM_ALARM = 4;
  localparam int YEAR_MAX  = 99;
`ifdef LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, load = 1'b0;
  logic [7:0] set_year = '0, set_month = '0, set_day = '0;
  logic [7:0] set_hour = '0, set_minute = '0, set_second = '0;
  logic load_err, tick_1hz;
  logic [7:0] year, month, day, hour, minute, second;
  logic alarm_wr = 1'b0, alarm_en_in = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic [7:0] alarm_hour = '0, alarm_minute = '0, alarm_second = '0;
  logic [NUM_ALARM-1:0] alarm_ack = '0;
  logic [NUM_ALARM-1:0] alarm_flag;
  logic alarm_any;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  watch_calendar_alarm #(.CLK_HZ(CLK_HZ), .NUM_ALARM(NUM_ALARM), .YEAR_MAX(YEAR_MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .load(load),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .load_err(load_err), .year(year), .month(month), .day(day),
    .hour(hour), .minute(minute), .second(second), .tick_1hz(tick_1hz),
    .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_hour(alarm_hour),
    .alarm_minute(alarm_minute), .alarm_second(alarm_second),
    .alarm_en_in(alarm_en_in), .alarm_ack(alarm_ack),
    .alarm_flag(alarm_flag), .alarm_any(alarm_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_presc;
  bit m_tick, m_lerr;
  int a_h[NUM_ALARM], a_mi[NUM_ALARM], a_s[NUM_ALARM];
  bit a_en[NUM_ALARM], a_flag[NUM_ALARM];

  function automatic int m_dim(input int mo, input int y);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo < 1 || mo > 12) return 0;
    if (mo == 2 && LEAP && (y % 4 == 0)) return 29;
    return tbl[mo-1];
  endfunction

  function automatic bit m_valid(input int y, input int mo, input int d,
                                 input int h, input int mi, input int s);
    return (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= m_dim(mo, y)) &&
           (h <= 23) && (mi <= 59) && (s <= 59) && (y <= YEAR_MAX);
  endfunction

  function automatic logic [NUM_ALARM-1:0] m_flags();
    logic [NUM_ALARM-1:0] f;
    for (int i = 0; i < NUM_ALARM; i++) f[i] = a_flag[i];
    return f;
  endfunction

  task automatic m_advance();
    m_s++;
    if (m_s == 60) begin
      m_s = 0; m_mi++;
      if (m_mi == 60) begin
        m_mi = 0; m_h++;
        if (m_h == 24) begin
          m_h = 0; m_d++;
          if (m_d > m_dim(m_mo, m_y)) begin
            m_d = 1; m_mo++;
            if (m_mo == 13) begin
              m_mo = 1; m_y++;
              if (m_y > YEAR_MAX) m_y = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic m_step();
    if (!rst) begin
      m_y = 0; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
      m_presc = 0; m_tick = 0; m_lerr = 0;
      for (int i = 0; i < NUM_ALARM; i++) begin
        a_h[i] = 0; a_mi[i] = 0; a_s[i] = 0; a_en[i] = 0; a_flag[i] = 0;
      end
    end else begin
      // alarms see the time and tick as they were before this edge
      for (int i = 0; i < NUM_ALARM; i++) begin
        if (alarm_wr && int'(alarm_sel) == i) begin
          a_h[i] = alarm_hour; a_mi[i] = alarm_minute; a_s[i] = alarm_second;
          a_en[i] = alarm_en_in; a_flag[i] = 0;
        end else if (m_tick && a_en[i] && a_h[i] == m_h && a_mi[i] == m_mi && a_s[i] == m_s) begin
          a_flag[i] = 1;
        end else if (alarm_ack[i]) begin
          a_flag[i] = 0;
        end
      end
      m_tick = 0;
      m_lerr = 0;
      if (load && m_valid(set_year, set_month, set_day, set_hour, set_minute, set_second)) begin
        m_y = set_year; m_mo = set_month; m_d = set_day;
        m_h = set_hour; m_mi = set_minute; m_s = set_second;
        m_presc = 0;
      end else begin
        m_lerr = load;
        if (run) begin
          if (m_presc == CLK_HZ - 1) begin
            m_presc = 0; m_tick = 1; m_advance();
          end else begin
            m_presc++;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    m_step();
  end

  // Compare every output against the model once per cycle
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cmp_year", year, m_y);
      chk("cmp_month", month, m_mo);
      chk("cmp_day", day, m_d);
      chk("cmp_hour", hour, m_h);
      chk("cmp_minute", minute, m_mi);
      chk("cmp_second", second, m_s);
      chk("cmp_tick", tick_1hz, m_tick);
      chk("cmp_load_err", load_err, m_lerr);
      chk("cmp_flag", alarm_flag, m_flags());
      chk("cmp_any", alarm_any, int'(m_flags() != '0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int y, input int mo, input int d,
                         input int h, input int mi, input int s);
    set_year = 8'(y); set_month = 8'(mo); set_day = 8'(d);
    set_hour = 8'(h); set_minute = 8'(mi); set_second = 8'(s);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_time(input string name, input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
    chk({name, "_year"}, year, y);
    chk({name, "_month"}, month, mo);
    chk({name, "_day"}, day, d);
    chk({name, "_hour"}, hour, h);
    chk({name, "_minute"}, minute, mi);
    chk({name, "_second"}, second, s);
  endtask

  task automatic wait_tick(input string name);
    int found = 0;
    for (int i = 0; i < 3 * CLK_HZ && found == 0; i++) begin
      @(negedge clk);
      if (tick_1hz) found = 1;
    end
    chk(name, found, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int tick_cnt, fnd;
    int sy, smo, sd, sh, smi, ss;
    int bad[4][6];

    #3 rst = 1'b0;
    cyc(2);
    cmp_en = 1'b1;
    chk_time("rst", 0, 1, 1, 0, 0, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_lerr", load_err, 0);
    chk("rst_flag", alarm_flag, 0);

    // 30 cycles from reset: ticks at 10, 20, 30
    run = 1'b1; rst = 1'b1;
    tick_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (tick_1hz) tick_cnt++;
      if (c % 10 == 0) chk($sformatf("tick_c%0d", c), tick_1hz, 1);
    end
    chk("tick_cnt", tick_cnt, 3);
    chk_time("t30", 0, 1, 1, 0, 0, 3);

    // alarm channel 2 at 00:00:05
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    alarm_wr = 1'b1; alarm_sel = 2'd2; alarm_hour = 8'd0; alarm_minute = 8'd0;
    alarm_second = 8'd5; alarm_en_in = 1'b1;
    cyc(1);
    alarm_wr = 1'b0;
    fnd = 0;
    for (int i = 0; i < 80 && fnd == 0; i++) begin
      @(negedge clk);
      if (tick_1hz && second == 8'd5) fnd = 1;
    end
    chk("alm_reach", fnd, 1);
    chk("alm_pre", alarm_flag, 0);
    alarm_ack = 4'b0100;
    cyc(1);
    chk("alm_set", alarm_flag, 4'b0100);
    chk("alm_any", alarm_any, 1);
    cyc(1);
    chk("alm_ack", alarm_flag, 0);
    chk("alm_any0", alarm_any, 0);
    alarm_ack = '0;
    cyc(8);
    chk("alm_noreset", alarm_flag, 0);

    // full rollover
    do_load(99, 12, 31, 23, 59, 59);
    chk_time("ld", 99, 12, 31, 23, 59, 59);
    wait_tick("ld_tick");
    chk_time("roll", 0, 1, 1, 0, 0, 0);

    // February
`ifdef LEAP_YEAR_EN
    do_load(24, 2, 28, 23, 59, 59);
    wait_tick("leap_tick");
    chk_time("leap", 24, 2, 29, 0, 0, 0);
    do_load(23, 2, 28, 23, 59, 59);
    wait_tick("nleap_tick");
    chk_time("nleap", 23, 3, 1, 0, 0, 0);
`else
    do_load(24, 2, 28, 23, 59, 59);
    wait_tick("feb_tick");
    chk_time("feb", 24, 3, 1, 0, 0, 0);
`endif

    // invalid loads with time frozen
    run = 1'b0;
    cyc(1);
    sy = year; smo = month; sd = day; sh = hour; smi = minute; ss = second;
    bad[0] = '{sy, 13, 1, 0, 0, 0};
    bad[1] = '{0, 1, 1, 24, 0, 0};
    bad[2] = '{0, 4, 31, 0, 0, 0};
    bad[3] = '{24, 2, 29, 0, 0, 0};
    for (int k = 0; k < (LEAP ? 3 : 4); k++) begin
      do_load(bad[k][0], bad[k][1], bad[k][2], bad[k][3], bad[k][4], bad[k][5]);
      chk($sformatf("lerr_%0d", k), load_err, 1);
      chk_time($sformatf("bad_%0d", k), sy, smo, sd, sh, smi, ss);
      cyc(1);
      chk($sformatf("lerr_w%0d", k), load_err, 0);
    end

    // frozen for 50 cycles
    tick_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tick_1hz) tick_cnt++;
    end
    chk("frz_ticks", tick_cnt, 0);
    chk_time("frz", sy, smo, sd, sh, smi, ss);
    do_load(10, 6, 15, 12, 30, 45);
    chk_time("frz_ld", 10, 6, 15, 12, 30, 45);

    // load coincident with prescaler wrap
    run = 1'b1;
    fnd = 0;
    for (int i = 0; i < 3 * CLK_HZ && fnd == 0; i++) begin
      if (m_presc == CLK_HZ - 1) fnd = 1;
      else @(negedge clk);
    end
    chk("wrap_found", fnd, 1);
    do_load(5, 7, 4, 8, 9, 10);
    chk("coinc_tick", tick_1hz, 0);
    chk_time("coinc", 5, 7, 4, 8, 9, 10);
    cyc(CLK_HZ - 1);
    chk("coinc_notick", tick_1hz, 0);
    cyc(1);
    chk("coinc_next", tick_1hz, 1);
    chk("coinc_sec", second, 11);

    // asynchronous reset mid-count
    cyc(7);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_time("arst", 0, 1, 1, 0, 0, 0);
    chk("arst_tick", tick_1hz, 0);
    chk("arst_lerr", load_err, 0);
    chk("arst_flag", alarm_flag, 0);
    chk("arst_any", alarm_any, 0);
    @(negedge clk);
    rst = 1'b1;
    tick_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c < 10 && tick_1hz) tick_cnt++;
      if (c == 10) chk("arst_tick10", tick_1hz, 1);
    end
    chk("arst_early", tick_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_calendar_alarm.md
# watch_calendar_alarm

Parametrised time-of-day and calendar core with built-in 1 Hz prescaler, validated bulk load and N independent alarm channels. It replaces the separate enable-divider, date-counter and set-path chain under the clock top level. Its binary outputs feed the existing bin2bcd/LCD path unchanged, and its alarm flags drive buzzer/LED logic.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; prescaler modulus
- NUM_ALARM, 4, alarm channel count (1..16)
- YEAR_MAX, 99, last year value before wrap to 0 (year = 2000 + value)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- run  in  1  1 = time advances; 0 = prescaler frozen
- load  in  1  single-cycle strobe: write set_* into calendar
- set_year, set_month, set_day, set_hour, set_minute, set_second  in  8 each  load values, binary
- load_err  out  1  one-cycle pulse: last load rejected
- year, month, day, hour, minute, second  out  8 each  current time, binary
- tick_1hz  out  1  one-cycle pulse per elapsed second
- alarm_wr  in  1  write strobe for one alarm channel
- alarm_sel  in  $clog2(NUM_ALARM) (min 1)  channel index
- alarm_hour, alarm_minute, alarm_second  in  8 each  alarm compare time
- alarm_en_in  in  1  channel enable value written with alarm_wr
- alarm_ack  in  NUM_ALARM  per-channel flag clear
- alarm_flag  out  NUM_ALARM  latched per-channel alarm
- alarm_any  out  1  OR of alarm_flag

## Operation
- Reset: year 0, month 1, day 1, hour/minute/second 0, prescaler 0, tick_1hz 0, load_err 0. All alarm channels disabled with compare time 00:00:00; alarm_flag 0.
- Prescaler counts 0..CLK_HZ-1 while run=1. On the edge where it wraps: tick_1hz=1 for one cycle and second increments on the same edge.
- Carry chain: second 59→0 carries to minute; 59→0 carries to hour; 23→0 carries to day. day == days_in_month(month, year) → 1, carries to month. 12→1 carries to year. YEAR_MAX→0.
- Load: accepted only if month 1..12, day 1..days_in_month(set_month, set_year), hour ≤23, minute ≤59, second ≤59, year ≤ YEAR_MAX.
  - Valid: all six fields update at the next edge; prescaler clears to 0.
  - Invalid: no state change; load_err=1 next cycle.
- Load in the same cycle as a prescaler wrap: load wins; no tick_1hz, no increment.
- Alarm write: channel alarm_sel takes compare time and enable; its flag clears. alarm_sel ≥ NUM_ALARM is ignored. Out-of-range compare values are stored and never match.
- Alarm match: evaluated only in the cycle tick_1hz=1, against the already-updated time. A channel with enable=1 and hour/minute/second equal sets its flag at the next edge. Load-induced matches never set flags.
- alarm_ack[i] clears flag i. Set and ack in the same cycle: set wins.
- run=0 freezes prescaler and time. Load and alarm writes still work.

## Timing
- Time outputs are registered. They change on the tick edge or one edge after load.
- alarm_flag rises one cycle after tick_1hz. alarm_any is combinational OR of registered flags.
- load_err latency: 1 cycle. Pulse width: 1 cycle.
- Async reset mid-operation returns everything to reset values immediately; counting resumes from prescaler 0 after deassertion.

## Configuration
- LEAP_YEAR_EN defined: February has 29 days when year[1:0]==0, applied to both counting and load validation.
- LEAP_YEAR_EN not defined: February is always 28 days; Feb 29 loads are rejected.

## Structure
- Package watch_pkg:
  - limit constants (SEC_MAX 59, MIN_MAX 59, HOUR_MAX 23, MONTH_MAX 12)
  - reset values
  - function days_in_month(month, year), which contains the LEAP_YEAR_EN conditional
- Sub-module watch_alarm_ch, instantiated NUM_ALARM times in a generate loop:
  - compare registers, enable, flag
  - write/ack/match logic
- Top: prescaler, carry chain, load validator, alarm select decode.

## Test plan
- CLK_HZ=10, reset, run=1, 30 cycles -> tick_1hz at cycles 10, 20, 30; second = 3; date 00-01-01.
- Load 23:59:59 on 99-12-31, one tick -> 00:00:00, year 0, month 1, day 1.
- LEAP_YEAR_EN defined: load 24-02-28 23:59:59, tick -> day 29. Repeat with year 23 -> month 3, day 1. Macro undefined: load 24-02-29 -> load_err pulse, time unchanged.
- Load month 13, then hour 24, then day 31 with month 4 -> load_err each time, no state change.
- Alarm ch2 = 00:00:05 enabled, from reset count 5 s -> alarm_flag = 4'b0100 one cycle after 5th tick, alarm_any=1. Assert alarm_ack[2] on the setting cycle -> flag still set. Ack next cycle -> cleared, no re-set during that second.
- Load coincident with prescaler wrap -> no tick, loaded values exact. run=0 for 50 cycles -> time unchanged. Async reset mid-count -> all outputs at reset values.
